fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Decoupled instruction-fetch front end; replaces the combinational inst_mem lookup in fetch.
//  Issues sequential word requests to an instruction memory over a valid/ready request channel with in-order responses.
//  Buffers returned words in a DEPTH-entry FIFO and drives the registered IF/ID outputs consumed by decode.
//  Handles decode stall (load-use hazard) and branch/jump redirect from the memory stage, with a flush.
// PARAMETERS
//  DEPTH     4       instruction FIFO entries; also the max of (FIFO occupancy + outstanding requests); power of 2, >=2
//  RESET_PC  32'h0   first fetch address after reset
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  imem_req_valid out  1   request valid
//  imem_req_ready in   1   memory accepts the request this cycle
//  imem_req_addr  out  32  word-aligned fetch address
//  imem_rsp_valid in   1   response valid; in order; >=1 cycle after acceptance; no backpressure
//  imem_rsp_data  in   32  instruction word
//  redirect       in   1   taken branch or jump (pc_src | jump)
//  redirect_pc    in   32  target address; bits[1:0] ignored
//  stall          in   1   decode hazard: hold the IF/ID outputs
//  d_valid        out  1   IF/ID holds a real instruction
//  d_inst         out  32  instruction to decode; 32'h0 (nop) when d_valid=0
//  d_pc           out  32  PC of d_inst
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; d_valid=0, d_inst=0, d_pc=0.
//  Request: imem_req_valid = !redirect && (occ + outstanding < DEPTH)
//  - imem_req_addr = {fetch_pc[31:2],2'b00}; addr and valid are stable while valid=1 and ready=0.
//  - Accepted (valid&ready): fetch_pc += 4 (wraps mod 2^32) and outstanding += 1.
//  Response: each imem_rsp_valid decrements outstanding.
//  - If drop>0: discard the word and decrement drop.
//  - Else: push {rsp_pc, data} to the FIFO and rsp_pc += 4.
//  - Credit rule guarantees no push when full; a push into a full FIFO is a design error, flagged by an assertion.
//  IF/ID update on each clk edge, in priority order:
//  1) redirect: d_valid=0, d_inst=0, d_pc holds; FIFO cleared; fetch_pc=rsp_pc=redirect_pc & ~3.
//     drop = outstanding minus the response consumed this cycle; outstanding keeps counting those responses.
//     Any response in the redirect cycle is discarded.
//  2) stall=1: d_* hold; no pop.
//  3) FIFO non-empty: pop head into d_*; d_valid=1.
//  4) FIFO empty: d_valid=0, d_inst=0 (bubble); d_pc holds.
//  Latency: a response at edge N is pushed at N and reaches d_* at edge N+1 when stall=0.
//  - No response-to-output bypass; minimum redirect-to-first-valid-d = memory latency + 2 cycles.
//  Simultaneous push and pop: both occur; occupancy unchanged.
//  - Credit uses the pre-pop occupancy, so the rule is conservative.
//  A redirect arriving while drop>0: drop is recomputed from the current outstanding count.
//  rst mid-transaction: all state clears. The memory must also be reset; stale responses after reset are not tolerated.
// TESTING
//  1. Reset, latency=1, ready=1, no stall.
//     -> requests at 0,4,8,...; d_pc=0,4,8 on consecutive cycles; d_inst matches the memory image.
//  2. stall high 3 cycles mid-stream at d_pc=8.
//     -> d_* hold at 8 for 3 cycles; next d_pc=12; no word lost or duplicated; occupancy never > 4.
//  3. ready=0 for 5 cycles, latency=3.
//     -> imem_req_addr held stable; no more than 4 words (outstanding + occupancy) in flight.
//  4. redirect to 32'h40 with 2 responses outstanding.
//     -> both dropped; d_valid=0 next edge; first valid d_pc=32'h40, then 32'h44.
//  5. redirect and imem_rsp_valid in the same cycle, plus redirect during stall.
//     -> response discarded; redirect wins over stall; d_inst=0.
//  6. redirect_pc=32'hFFFFFFFC.
//     -> fetch addresses FFFFFFFC then 0; d_pc wraps identically.
//  7. rst asserted asynchronously mid-stream.
//     -> all outputs reset immediately; restart fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction-fetch front end.
// Streams sequential word requests to instruction memory, buffers the in-order
// responses in a small FIFO and feeds the registered IF/ID stage used by decode.
// Redirects flush the FIFO and discard responses that are still in flight.

module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        d_valid,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Architectural PCs: next address to request and PC of the next word to arrive
  logic [31:0] fetch_pc;
  logic [31:0] rsp_pc;

  // Instruction FIFO storage and bookkeeping
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  cnt_t        occ;

  // Requests accepted but not yet answered, and answers still to be thrown away
  cnt_t        outstanding;
  cnt_t        drop;

  logic [CW:0] credit_used;
  cnt_t        outstanding_after_rsp;
  logic        req_accept;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [31:0] redirect_target;

  // Request credit, handshake decode and FIFO push/pop qualification
  always_comb begin
    credit_used           = {1'b0, occ} + {1'b0, outstanding};
    imem_req_valid        = !redirect && (credit_used < {1'b0, DEPTH_C});
    imem_req_addr         = {fetch_pc[31:2], 2'b00};
    req_accept            = imem_req_valid && imem_req_ready;
    outstanding_after_rsp = outstanding - cnt_t'(imem_rsp_valid);
    fifo_empty            = (occ == '0);
    fifo_full             = (occ == DEPTH_C);
    push                  = imem_rsp_valid && !redirect && (drop == '0);
    pop                   = !redirect && !stall && !fifo_empty;
    redirect_target       = {redirect_pc[31:2], 2'b00};
  end

  // Fetch PC advances on each accepted request; response PC on each kept word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      rsp_pc   <= redirect_target;
    end else begin
      if (req_accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

  // In-flight tracking; a redirect turns everything still in flight into drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_after_rsp + cnt_t'(req_accept);
      if (redirect) begin
        drop <= outstanding_after_rsp;
      end else if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // FIFO storage holds PC alongside the word so decode sees matching pairs
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

  // IF/ID register: redirect squashes, stall holds, otherwise pop or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_inst  <= '0;
      d_pc    <= '0;
    end else if (redirect) begin
      d_valid <= 1'b0;
      d_inst  <= '0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        d_valid <= 1'b1;
        d_inst  <= fifo_inst[rd_ptr];
        d_pc    <= fifo_pc[rd_ptr];
      end else begin
        d_valid <= 1'b0;
        d_inst  <= '0;
      end
    end
  end

  // The credit limit must make it impossible to push into a full queue
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

  // Memory must never answer a request that was not made
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding != '0));

endmodule
